// File: rtl/sys_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : sys_mem_responder - wait-stated single-word memory on the system bus
// Rev     : 1.0  initial release
// ============================================================================
module sys_mem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int WAITSTATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SysStrobe,
    input  logic              SysRW,
    input  logic [ADDR_W-1:0] SysAddr,
    input  logic [DATA_W-1:0] SysDataIn,
    output logic [DATA_W-1:0] SysDataOut,
    output logic              SysDataOE,
    output logic              SysReady,
    output logic              SysBusy,
    output logic              SysError,
    input  logic              ErrorClr
);
    localparam int              MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (WAITSTATES == 0) ? 4'd0 : 4'(WAITSTATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;

    logic              eff_rw;
    logic [ADDR_W-1:0] eff_addr;
    logic              eff_in_range;
    logic              entering_data;
    logic              wr_in_range;

    // State register and all datapath flops
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
        end
    end

    // Next-state and request capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (SysStrobe) begin
                    rw_d    = SysRW;
                    addr_d  = SysAddr;
                    wdata_d = SysDataIn;
                    cnt_d   = CNT_INIT;
                    state_d = (WAITSTATES == 0) ? S_DATA : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DATA: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: read data is fetched on the edge entering DATA so it is
    // registered yet valid throughout the DATA cycle, even with zero wait states.
    always_comb begin
        eff_rw        = (state_q == S_IDLE) ? SysRW   : rw_q;
        eff_addr      = (state_q == S_IDLE) ? SysAddr : addr_q;
        eff_in_range  = ({1'b0, eff_addr} < DEPTH_L);
        entering_data = (state_d == S_DATA);

        oe_d       = entering_data && eff_rw;
        data_out_d = '0;
        if (oe_d && eff_in_range) begin
            data_out_d = mem[eff_addr[MEM_AW-1:0]];
        end

        err_d = err_q;
        if (ErrorClr) begin
            err_d = 1'b0;
        end
        if ((SysStrobe && (state_q != S_IDLE)) || (entering_data && !eff_in_range)) begin
            err_d = 1'b1;
        end
    end

    assign wr_in_range = ({1'b0, addr_q} < DEPTH_L);

    // Async reset forces state_q out of DATA, so an aborted write never commits.
    always_ff @(posedge Clk) begin
        if ((state_q == S_DATA) && !rw_q && wr_in_range) begin
            mem[addr_q[MEM_AW-1:0]] <= wdata_q;
        end
    end

    assign SysDataOut = data_out_q;
    assign SysDataOE  = oe_q;
    assign SysReady   = (state_q == S_DATA);
    assign SysBusy    = (state_q != S_IDLE);
    assign SysError   = err_q;

endmodule
`default_nettype wire
